add_round_key_seq: RTL

//  Sequences one AddRoundKey pass of AES-128 decryption through the shared
//  32-bit column XOR datapath, one column per cycle (column 0 first).

---
 rtl/add_round_key_seq_if.sv | 37 +++
 rtl/add_round_key_seq.sv | 92 +++++++++
 2 files changed

// File: rtl/add_round_key_seq_if.sv
// Bus bundle for add_round_key_seq.
//  Upstream side  : flush, in_valid/in_ready, state_in, key_in
//  XOR unit side  : xor_data, xor_key, xor_sel out; xor_result back in
//  Downstream side: out_valid/out_ready, out_data; busy status
// The slave modport is the sequencer; the master modport is everything around it
// (round controller, external XOR unit and downstream stage).
interface add_round_key_seq_if #(
    parameter int unsigned COL_W = 32,
    parameter int unsigned NCOL  = 4
);
    localparam int unsigned BW   = NCOL * COL_W;
    localparam int unsigned SELW = $clog2(NCOL);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [BW-1:0]    state_in;
    logic [BW-1:0]    key_in;
    logic [COL_W-1:0] xor_data;
    logic [BW-1:0]    xor_key;
    logic [SELW-1:0]  xor_sel;
    logic [COL_W-1:0] xor_result;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [BW-1:0]    out_data;

    modport slave (
        input  flush, in_valid, state_in, key_in, xor_result, out_ready,
        output in_ready, xor_data, xor_key, xor_sel, busy, out_valid, out_data
    );

    modport master (
        output flush, in_valid, state_in, key_in, xor_result, out_ready,
        input  in_ready, xor_data, xor_key, xor_sel, busy, out_valid, out_data
    );
endinterface

// File: rtl/add_round_key_seq.sv
// AddRoundKey sequencer for AES-128 decryption.
// Latches a state/key pair, then drives one column per cycle (column 0 first)
// through an external combinational XOR unit and collects the results into a
// registered output block held until the downstream handshake.
//  clk   : rising-edge clock
//  reset : asynchronous active-high reset
//  bus   : add_round_key_seq_if.slave (handshakes, XOR unit port, output block)
// Column c of any block occupies bits [BW-1-c*COL_W -: COL_W].
module add_round_key_seq #(
    parameter int unsigned COL_W = 32,
    parameter int unsigned NCOL  = 4
) (
    input  logic clk,
    input  logic reset,
    add_round_key_seq_if.slave bus
);
    localparam int unsigned BW   = NCOL * COL_W;
    localparam int unsigned SELW = $clog2(NCOL);
    localparam logic [SELW-1:0] LAST_COL = SELW'(NCOL - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [SELW-1:0]  col_idx;
    logic [COL_W-1:0] state_col  [NCOL];
    logic [COL_W-1:0] result_col [NCOL];
    logic [COL_W-1:0] state_in_col [NCOL];
    logic [BW-1:0]    key_q;
    logic             accept;

    // Column views of the packed input and output blocks.
    for (genvar g = 0; g < NCOL; g++) begin : g_col
        assign state_in_col[g] = bus.state_in[BW-1-g*COL_W -: COL_W];
        assign bus.out_data[BW-1-g*COL_W -: COL_W] = result_col[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        bus.in_ready = (state_q == IDLE);
        bus.busy     = (state_q == BUSY);
        bus.out_valid = (state_q == DONE);
        bus.xor_sel  = '0;
        bus.xor_data = '0;
        bus.xor_key  = key_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.xor_sel  = col_idx;
                bus.xor_data = state_col[col_idx];
                if (col_idx == LAST_COL) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // flush overrides every other event, including a same-cycle accept
        if (bus.flush) begin
            accept  = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_idx    <= '0;
            key_q      <= '0;
            state_col  <= '{default: '0};
            result_col <= '{default: '0};
        end else if (bus.flush) begin
            col_idx <= '0;
        end else if (accept) begin
            col_idx   <= '0;
            key_q     <= bus.key_in;
            state_col <= state_in_col;
        end else if (state_q == BUSY) begin
            result_col[col_idx] <= bus.xor_result;
            col_idx             <= col_idx + 1'b1;
        end
    end
endmodule
